seg7_scan_ctrl: RTL and testbench



---
 rtl/seg7_pkg.sv | 44 ++++
 rtl/seg7_decode_reg.sv | 35 +++
 rtl/seg7_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the two-digit 7-segment scan path: scan states,
// segment codes ({g,f,e,d,c,b,a}, active-high) and the BCD decoder.
package seg7_pkg;

    typedef enum logic [1:0] {
        S_BLK0 = 2'd0,
        S_HI   = 2'd1,
        S_BLK1 = 2'd2,
        S_LO   = 2'd3
    } seg7_state_e;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    // Non-decimal codes (10-15) show a dash rather than hex glyphs.
    function automatic logic [6:0] seg7_decode(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_decode_reg.sv
// Registered BCD-to-7-segment decoder with selectable output polarity.
// Resets to the blank pattern of the chosen polarity.
module seg7_decode_reg
    import seg7_pkg::*;
#(
    parameter bit SEG_ACT_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    localparam logic [6:0] POL = SEG_ACT_LOW ? 7'h7F : 7'h00;

    logic [6:0] seg_q;
    logic [6:0] seg_d;

    // Decode and apply panel polarity.
    always_comb begin
        seg_d = seg7_decode(bcd_i) ^ POL;
    end

    // Output register; blank on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= SEG_OFF ^ POL;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign seg_o = seg_q;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Two-digit 7-segment scan controller. Scans BLK0 -> HI -> BLK1 -> LO with
// a down-counter; the blank slots let the mux select settle before any
// digit enable rises. New digits are staged in shadow registers and only
// become visible at a frame boundary, so a frame never shows mixed data.
// load is a single-cycle strobe with no back-pressure: every high cycle is
// captured, and the last capture before a frame boundary wins.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 50000,
    parameter int unsigned BLANK_CYC   = 16,
    parameter bit          SEG_ACT_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] bcd_hi,
    input  logic [3:0] bcd_lo,
    output logic       sel,
    output logic [6:0] seg_hi,
    output logic [6:0] seg_lo,
    output logic [1:0] digit_en,
    output logic       frame_done
);

    localparam int unsigned CNT_MAX = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DIV_RLD = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLK_RLD = CNT_W'(BLANK_CYC - 1);

    seg7_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic [1:0]       en_q, en_d;
    logic             fd_q, fd_d;

    logic [3:0]       sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;
    logic [3:0]       act_hi_q, act_hi_d, act_lo_q, act_lo_d;
    logic             pend_q, pend_d;

    // Last cycle of S_LO: the next edge closes the frame.
    logic frame_end;
    assign frame_end = (state_q == S_LO) && (cnt_q == '0);

    // Next state, slot counter, and the registered outputs of the next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
            case (state_q)
                S_BLK0:  begin state_d = S_HI;   cnt_d = DIV_RLD; end
                S_HI:    begin state_d = S_BLK1; cnt_d = BLK_RLD; end
                S_BLK1:  begin state_d = S_LO;   cnt_d = DIV_RLD; end
                default: begin state_d = S_BLK0; cnt_d = BLK_RLD; end
            endcase
        end
        sel_d = 1'b1;
        en_d  = 2'b00;
        case (state_d)
            S_HI:    en_d  = 2'b10;
            S_BLK1:  sel_d = 1'b0;
            S_LO:    begin sel_d = 1'b0; en_d = 2'b01; end
            default: ;
        endcase
        fd_d = frame_end;
    end

    // Shadow capture and frame-boundary promotion; a load on the boundary
    // edge bypasses the shadow and lands in the active regs directly.
    always_comb begin
        sh_hi_d  = sh_hi_q;
        sh_lo_d  = sh_lo_q;
        act_hi_d = act_hi_q;
        act_lo_d = act_lo_q;
        pend_d   = pend_q;
        if (load) begin
            sh_hi_d = bcd_hi;
            sh_lo_d = bcd_lo;
            pend_d  = 1'b1;
        end
        if (frame_end) begin
            if (load) begin
                act_hi_d = bcd_hi;
                act_lo_d = bcd_lo;
                pend_d   = 1'b0;
            end else if (pend_q) begin
                act_hi_d = sh_hi_q;
                act_lo_d = sh_lo_q;
                pend_d   = 1'b0;
            end
        end
    end

    // State, counter, scan outputs and digit registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_BLK0;
            cnt_q    <= BLK_RLD;
            sel_q    <= 1'b1;
            en_q     <= 2'b00;
            fd_q     <= 1'b0;
            sh_hi_q  <= '0;
            sh_lo_q  <= '0;
            act_hi_q <= '0;
            act_lo_q <= '0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            en_q     <= en_d;
            fd_q     <= fd_d;
            sh_hi_q  <= sh_hi_d;
            sh_lo_q  <= sh_lo_d;
            act_hi_q <= act_hi_d;
            act_lo_q <= act_lo_d;
            pend_q   <= pend_d;
        end
    end

    seg7_decode_reg #(.SEG_ACT_LOW(SEG_ACT_LOW)) u_dec_hi (
        .clk   (clk),
        .rst   (rst),
        .bcd_i (act_hi_q),
        .seg_o (seg_hi)
    );

    seg7_decode_reg #(.SEG_ACT_LOW(SEG_ACT_LOW)) u_dec_lo (
        .clk   (clk),
        .rst   (rst),
        .bcd_i (act_lo_q),
        .seg_o (seg_lo)
    );

    assign sel        = sel_q;
    assign digit_en   = en_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: an active-high and an active-low instance share
// the same stimulus and are compared every cycle against a frame-position
// reference model.
module tb_seg7_scan_ctrl;

    localparam int CLK_DIV   = 4;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = 2 * (CLK_DIV + BLANK_CYC);
    localparam int W         = 36;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       load   = 1'b0;
    logic [3:0] bcd_hi = '0;
    logic [3:0] bcd_lo = '0;

    logic       sel, frame_done, sel_al, frame_done_al;
    logic [1:0] digit_en, digit_en_al;
    logic [6:0] seg_hi, seg_lo, seg_hi_al, seg_lo_al;

    seg7_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC), .SEG_ACT_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .load(load), .bcd_hi(bcd_hi), .bcd_lo(bcd_lo),
        .sel(sel), .seg_hi(seg_hi), .seg_lo(seg_lo), .digit_en(digit_en),
        .frame_done(frame_done)
    );

    seg7_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC), .SEG_ACT_LOW(1'b1)) dut_al (
        .clk(clk), .rst(rst), .load(load), .bcd_hi(bcd_hi), .bcd_lo(bcd_lo),
        .sel(sel_al), .seg_hi(seg_hi_al), .seg_lo(seg_lo_al), .digit_en(digit_en_al),
        .frame_done(frame_done_al)
    );

    // Clock
    always #5 clk = ~clk;

    // Scoreboard state
    int             n_cmp = 0;
    int             n_bad = 0;
    logic [W-1:0]   exp_q[$];

    // Reference model state
    int         t;
    logic [3:0] act_hi, act_lo, pend_hi, pend_lo, shown_hi, shown_lo;
    bit         pend, live;
    logic       prev_sel;
    int         last_fd;

    typedef struct {
        logic [3:0] hi;
        logic [3:0] lo;
        logic [6:0] seg_hi;
        logic [6:0] seg_lo;
    } vec_t;
    vec_t tbl[10];

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        case (v)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    // Expected outputs of both instances from the position inside the frame.
    function automatic logic [W-1:0] exp_vec(input int tt, input bit lv,
                                             input logic [3:0] h, input logic [3:0] l);
        int         p;
        logic       s;
        logic [1:0] en;
        logic       fd;
        logic [6:0] sh, sl;
        p  = tt % FRAME;
        s  = (p < BLANK_CYC + CLK_DIV);
        if (p < BLANK_CYC)                     en = 2'b00;
        else if (p < BLANK_CYC + CLK_DIV)      en = 2'b10;
        else if (p < 2 * BLANK_CYC + CLK_DIV)  en = 2'b00;
        else                                   en = 2'b01;
        fd = (p == 0) && (tt >= FRAME);
        sh = lv ? ref_seg(h) : 7'h00;
        sl = lv ? ref_seg(l) : 7'h00;
        return {s, en, fd, sh, sl, s, en, fd, ~sh, ~sl};
    endfunction

    function automatic logic [W-1:0] dut_vec();
        return {sel, digit_en, frame_done, seg_hi, seg_lo,
                sel_al, digit_en_al, frame_done_al, seg_hi_al, seg_lo_al};
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, t);
        end
    endtask

    task automatic model_reset();
        t = 0; act_hi = '0; act_lo = '0; pend_hi = '0; pend_lo = '0;
        shown_hi = '0; shown_lo = '0; pend = 0; live = 0;
        prev_sel = 1'b1; last_fd = -1;
        exp_q.delete();
        exp_q.push_back(exp_vec(0, 1'b0, 4'd0, 4'd0));
    endtask

    // One clock edge of the reference model: digits latched during a frame
    // become visible from the next frame, decoded one cycle later.
    task automatic model_step();
        shown_hi = act_hi;
        shown_lo = act_lo;
        live     = 1;
        if (load) begin
            pend_hi = bcd_hi;
            pend_lo = bcd_lo;
            pend    = 1;
        end
        if ((t % FRAME == FRAME - 1) && pend) begin
            act_hi = pend_hi;
            act_lo = pend_lo;
            pend   = 0;
        end
        t++;
        exp_q.push_back(exp_vec(t, live, shown_hi, shown_lo));
    endtask

    task automatic score();
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_empty: got no expectation at t=%0d", t);
        end else begin
            e = exp_q.pop_front();
            chk("cycle_outputs", dut_vec(), e);
        end
        n_cmp++;
        if (digit_en === 2'b11) begin
            n_bad++;
            $display("FAIL digit_en_onehot: got %b required not 11", digit_en);
        end
        if (sel !== prev_sel) begin
            chk("sel_change_blanked", {34'd0, digit_en}, {34'd0, 2'b00});
        end
        prev_sel = sel;
        if (frame_done === 1'b1) begin
            if (last_fd >= 0) chk("frame_period", W'(t - last_fd), W'(FRAME));
            last_fd = t;
        end
    endtask

    // Driver: apply inputs for one cycle, advance model, check at negedge.
    task automatic cycle(input bit ld, input logic [3:0] h, input logic [3:0] l);
        load   = ld;
        bcd_hi = h;
        bcd_lo = l;
        @(posedge clk);
        model_step();
        @(negedge clk);
        load = 1'b0;
        score();
    endtask

    task automatic run_to(input int p);
        do cycle(1'b0, 4'd0, 4'd0); while (t % FRAME != p);
    endtask

    // Asynchronous reset: outputs must go to reset values without a clock.
    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        load = 1'b0;
        #1;
        chk("rst_digit_en",   W'(digit_en),  W'(2'b00));
        chk("rst_sel",        W'(sel),       W'(1'b1));
        chk("rst_frame_done", W'(frame_done), W'(1'b0));
        chk("rst_seg_hi",     W'(seg_hi),    W'(7'h00));
        chk("rst_seg_lo",     W'(seg_lo),    W'(7'h00));
        chk("rst_seg_hi_al",  W'(seg_hi_al), W'(7'h7F));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        score();
    endtask

    initial begin
        logic [6:0] e_al;
        tbl[0] = '{4'd0,  4'd1,  7'h3F, 7'h06};
        tbl[1] = '{4'd2,  4'd3,  7'h5B, 7'h4F};
        tbl[2] = '{4'd4,  4'd5,  7'h66, 7'h6D};
        tbl[3] = '{4'd6,  4'd7,  7'h7D, 7'h07};
        tbl[4] = '{4'd8,  4'd9,  7'h7F, 7'h6F};
        tbl[5] = '{4'd10, 4'd11, 7'h40, 7'h40};
        tbl[6] = '{4'd12, 4'd13, 7'h40, 7'h40};
        tbl[7] = '{4'd14, 4'd15, 7'h40, 7'h40};
        tbl[8] = '{4'd9,  4'd8,  7'h6F, 7'h7F};
        tbl[9] = '{4'd5,  4'd0,  7'h6D, 7'h3F};

        // Reset release and first frame with no load.
        do_reset();
        repeat (FRAME) cycle(1'b0, 4'd0, 4'd0);
        chk("first_frame_done", W'(frame_done), W'(1'b1));
        chk("idle_seg_hi",      W'(seg_hi),     W'(7'h3F));
        chk("idle_seg_lo",      W'(seg_lo),     W'(7'h3F));

        // Load in the middle of S_HI: held back until the frame boundary.
        run_to(BLANK_CYC + 1);
        cycle(1'b1, 4'd7, 4'd2);
        run_to(0);
        chk("held_seg_hi", W'(seg_hi), W'(7'h3F));
        chk("held_seg_lo", W'(seg_lo), W'(7'h3F));
        cycle(1'b0, 4'd0, 4'd0);
        chk("new_seg_hi", W'(seg_hi), W'(7'h07));
        chk("new_seg_lo", W'(seg_lo), W'(7'h5B));

        // Load exactly on the S_LO -> S_BLK0 edge applies to this frame.
        run_to(FRAME - 1);
        cycle(1'b1, 4'd9, 4'd15);
        cycle(1'b0, 4'd0, 4'd0);
        chk("edge_seg_hi",  W'(seg_hi),     W'(7'h6F));
        chk("edge_seg_lo",  W'(seg_lo),     W'(7'h40));
        chk("edge_pend",    W'(dut.pend_q), W'(1'b0));

        // Repeated loads within one frame: last one wins.
        run_to(BLANK_CYC + 1);
        cycle(1'b1, 4'd1, 4'd1);
        cycle(1'b1, 4'd3, 4'd4);
        run_to(1);
        chk("last_wins_hi", W'(seg_hi), W'(7'h4F));
        chk("last_wins_lo", W'(seg_lo), W'(7'h66));

        // Decode table through both polarities.
        for (int i = 0; i < 10; i++) begin
            run_to(BLANK_CYC + 1);
            cycle(1'b1, tbl[i].hi, tbl[i].lo);
            run_to(1);
            chk("tbl_seg_hi", W'(seg_hi), W'(tbl[i].seg_hi));
            chk("tbl_seg_lo", W'(seg_lo), W'(tbl[i].seg_lo));
            e_al = ~tbl[i].seg_hi;
            chk("tbl_seg_hi_al", W'(seg_hi_al), W'(e_al));
            e_al = ~tbl[i].seg_lo;
            chk("tbl_seg_lo_al", W'(seg_lo_al), W'(e_al));
        end

        // Reset in the middle of S_LO, then the restart timing.
        run_to(2 * BLANK_CYC + CLK_DIV + 1);
        chk("pre_rst_in_lo", W'(digit_en), W'(2'b01));
        do_reset();
        repeat (FRAME) cycle(1'b0, 4'd0, 4'd0);
        chk("restart_frame_done", W'(frame_done), W'(1'b1));

        // Random loads.
        for (int i = 0; i < 1000; i++) begin
            cycle(($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
